// File: rtl/j1_io_pkg.sv
// Shared definitions for the J1 UART I/O peripheral.
// Contents:
//   - register offsets inside the 4-word window (io_addr[1:0])
//   - bit positions of the STATUS register
//   - uart_state_e, the state type used by both the TX and RX serial FSMs
package j1_io_pkg;

  // Word offsets within the register window
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS bit positions; CTRL reuses the two sticky-flag positions as clear bits
  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_FRAME_ERR  = 5;
  localparam int STATUS_BITS   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/j1_uart_io_if.sv
// J1 I/O bus between the core (master) and a responding peripheral (slave).
// Signals:
//   io_addr  - I/O address (core mem_addr)
//   io_wr    - single-cycle write strobe
//   io_rd    - single-cycle read strobe
//   io_wdata - write data (core dout)
//   io_din   - registered read data returned by the peripheral
interface j1_uart_io_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] io_addr;
  logic                  io_wr;
  logic                  io_rd;
  logic [WIDTH-1:0]      io_wdata;
  logic [WIDTH-1:0]      io_din;

  modport master (
    output io_addr,
    output io_wr,
    output io_rd,
    output io_wdata,
    input  io_din
  );

  modport slave (
    input  io_addr,
    input  io_wr,
    input  io_rd,
    input  io_wdata,
    output io_din
  );
endinterface

// File: rtl/j1_fifo.sv
// Single-clock synchronous FIFO with show-ahead read data.
// Ports:
//   clk, resetq - clock, asynchronous active-low reset (FIFO empties)
//   push_i      - write data_i this cycle (dropped when full unless popping)
//   pop_i       - remove the head entry (ignored when empty)
//   data_i      - write data
//   data_o      - current head entry, valid while empty_o is low
//   full_o      - all 2**AW entries occupied
//   empty_o     - no entries
module j1_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rdPtr_q];

  // A push into a full FIFO still lands when the head is leaving on the
  // same edge (the write slot is the one being freed). A pop from an empty
  // FIFO never happens, so an empty push+pop only accepts the push.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || pop_i);

  // Storage array; contents need no reset because count_q gates validity
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_ONE;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PTR_ONE;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/j1_uart_io.sv
// Memory-mapped 8N1 UART responding on the J1 core's I/O bus.
// Ports:
//   clk, resetq - clock, asynchronous active-low reset
//   bus         - J1 I/O bus (slave side): io_addr, io_wr, io_rd, io_wdata in,
//                 registered io_din out
//   uart_tx     - serial output, idle high
//   uart_rx     - serial input, asynchronous to clk
//   irq         - high while the RX FIFO holds at least one byte
// Registers (word offset within BASE_ADDR window):
//   0 DATA   write: queue a TX byte; read: pop an RX byte (0 when empty)
//   1 STATUS tx_full, tx_empty, rx_valid, rx_full, rx_overrun, frame_err
//   2 CTRL   write 1 to bit4/bit5 to clear rx_overrun/frame_err
//   3        reserved
module j1_uart_io
  import j1_io_pkg::*;
#(
  parameter int                    WIDTH      = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1000,
  parameter int                    CLK_DIV    = 434,
  parameter int                    FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        resetq,
  j1_uart_io_if.slave bus,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  logic             hit;
  logic [1:0]       regSel;
  logic             wrHit;
  logic             rdHit;
  logic             txPush;
  logic             clrOverrun;
  logic             clrFrameErr;
  logic [WIDTH-1:0] rdData;
  logic [WIDTH-1:0] ioDin_q;
  logic [STATUS_BITS-1:0] status;
  logic             unusedWdata;

  logic       txFull;
  logic       txEmpty;
  logic [7:0] txFifoData;
  logic       txPop;
  logic       rxFull;
  logic       rxEmpty;
  logic [7:0] rxFifoData;
  logic       rxPop;
  logic       rxPush;

  logic rxOverrunSet;
  logic frameErrSet;
  logic rxOverrun_q;
  logic frameErr_q;

  uart_state_e txState_q, txState_d;
  logic [CW-1:0] txCnt_q, txCnt_d;
  logic [7:0]    txShift_q, txShift_d;
  logic [2:0]    txBit_q, txBit_d;
  logic          txLine_q, txLine_d;

  logic rxMeta_q;
  logic rxSync_q;
  logic rxPrev_q;
  uart_state_e rxState_q, rxState_d;
  logic [CW-1:0] rxCnt_q, rxCnt_d;
  logic [7:0]    rxShift_q, rxShift_d;
  logic [2:0]    rxBit_q, rxBit_d;

  // Address decode: the window is four words, the low two bits pick the register
  assign hit         = (bus.io_addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
  assign regSel      = bus.io_addr[1:0];
  assign wrHit       = bus.io_wr && hit;
  assign rdHit       = bus.io_rd && hit;
  assign txPush      = wrHit && (regSel == REG_DATA);
  assign clrOverrun  = wrHit && (regSel == REG_CTRL) && bus.io_wdata[ST_RX_OVERRUN];
  assign clrFrameErr = wrHit && (regSel == REG_CTRL) && bus.io_wdata[ST_FRAME_ERR];
  assign rxPop       = rdHit && (regSel == REG_DATA) && !rxEmpty;
  assign unusedWdata = ^bus.io_wdata[WIDTH-1:8];

  assign irq     = !rxEmpty;
  assign uart_tx = txLine_q;
  assign bus.io_din = ioDin_q;

  j1_fifo #(.WIDTH(8), .AW(FIFO_AW)) txFifo (
    .clk     (clk),
    .resetq  (resetq),
    .push_i  (txPush),
    .pop_i   (txPop),
    .data_i  (bus.io_wdata[7:0]),
    .data_o  (txFifoData),
    .full_o  (txFull),
    .empty_o (txEmpty)
  );

  j1_fifo #(.WIDTH(8), .AW(FIFO_AW)) rxFifo (
    .clk     (clk),
    .resetq  (resetq),
    .push_i  (rxPush),
    .pop_i   (rxPop),
    .data_i  (rxShift_q),
    .data_o  (rxFifoData),
    .full_o  (rxFull),
    .empty_o (rxEmpty)
  );

  // STATUS image; tx_empty also requires the shifter to be idle so software
  // can tell when the last stop bit has actually left the pin
  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = txFull;
    status[ST_TX_EMPTY]   = txEmpty && (txState_q == IDLE);
    status[ST_RX_VALID]   = !rxEmpty;
    status[ST_RX_FULL]    = rxFull;
    status[ST_RX_OVERRUN] = rxOverrun_q;
    status[ST_FRAME_ERR]  = frameErr_q;
  end

  // Read mux; CTRL and the reserved slot read back as zero
  always_comb begin
    rdData = '0;
    case (regSel)
      REG_DATA: begin
        if (!rxEmpty) begin
          rdData[7:0] = rxFifoData;
        end
      end
      REG_STATUS: rdData[STATUS_BITS-1:0] = status;
      default: rdData = '0;
    endcase
  end

  // Read data register: only a hit read updates it, so misses leave the
  // previous value visible to the core
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      ioDin_q <= '0;
    end else if (rdHit) begin
      ioDin_q <= rdData;
    end
  end

  // Sticky error flags; a new error on the same edge as a clear wins so that
  // an event is never silently lost
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rxOverrun_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      if (rxOverrunSet) begin
        rxOverrun_q <= 1'b1;
      end else if (clrOverrun) begin
        rxOverrun_q <= 1'b0;
      end
      if (frameErrSet) begin
        frameErr_q <= 1'b1;
      end else if (clrFrameErr) begin
        frameErr_q <= 1'b0;
      end
    end
  end

  // TX state register; the line is registered so reset forces it high at once
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      txState_q <= IDLE;
      txCnt_q   <= '0;
      txShift_q <= '0;
      txBit_q   <= '0;
      txLine_q  <= 1'b1;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txShift_q <= txShift_d;
      txBit_q   <= txBit_d;
      txLine_q  <= txLine_d;
    end
  end

  // TX next state: every state lasts CLK_DIV clocks; the end of STOP chains
  // straight into the next START when more bytes are queued
  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q;
    txShift_d = txShift_q;
    txBit_d   = txBit_q;
    txLine_d  = txLine_q;
    txPop     = 1'b0;
    case (txState_q)
      IDLE: begin
        txLine_d = 1'b1;
        if (!txEmpty) begin
          txPop     = 1'b1;
          txShift_d = txFifoData;
          txCnt_d   = BIT_RELOAD;
          txLine_d  = 1'b0;
          txState_d = START;
        end
      end
      START: begin
        if (txCnt_q == '0) begin
          txState_d = DATA;
          txCnt_d   = BIT_RELOAD;
          txBit_d   = '0;
          txLine_d  = txShift_q[0];
        end else begin
          txCnt_d = txCnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (txCnt_q == '0) begin
          txCnt_d = BIT_RELOAD;
          if (txBit_q == 3'd7) begin
            txState_d = STOP;
            txLine_d  = 1'b1;
          end else begin
            txBit_d   = txBit_q + 3'd1;
            txShift_d = {1'b0, txShift_q[7:1]};
            txLine_d  = txShift_q[1];
          end
        end else begin
          txCnt_d = txCnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (txCnt_q == '0) begin
          if (!txEmpty) begin
            txPop     = 1'b1;
            txShift_d = txFifoData;
            txCnt_d   = BIT_RELOAD;
            txLine_d  = 1'b0;
            txState_d = START;
          end else begin
            txLine_d  = 1'b1;
            txState_d = IDLE;
          end
        end else begin
          txCnt_d = txCnt_q - CNT_ONE;
        end
      end
      default: txState_d = IDLE;
    endcase
  end

  // RX synchronizer plus one extra stage for falling-edge detection; all
  // reset to the idle (high) level so reset never looks like a start bit
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= uart_rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rxState_q <= IDLE;
      rxCnt_q   <= '0;
      rxShift_q <= '0;
      rxBit_q   <= '0;
    end else begin
      rxState_q <= rxState_d;
      rxCnt_q   <= rxCnt_d;
      rxShift_q <= rxShift_d;
      rxBit_q   <= rxBit_d;
    end
  end

  // RX next state: the half-bit wait in START moves every later sample to
  // the middle of its bit. An overrun only occurs when the FIFO is full and
  // the core is not popping on the same edge.
  always_comb begin
    rxState_d    = rxState_q;
    rxCnt_d      = rxCnt_q;
    rxShift_d    = rxShift_q;
    rxBit_d      = rxBit_q;
    rxPush       = 1'b0;
    rxOverrunSet = 1'b0;
    frameErrSet  = 1'b0;
    case (rxState_q)
      IDLE: begin
        if (rxPrev_q && !rxSync_q) begin
          rxState_d = START;
          rxCnt_d   = HALF_RELOAD;
        end
      end
      START: begin
        if (rxCnt_q == '0) begin
          if (rxSync_q) begin
            rxState_d = IDLE;
          end else begin
            rxState_d = DATA;
            rxCnt_d   = BIT_RELOAD;
            rxBit_d   = '0;
          end
        end else begin
          rxCnt_d = rxCnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (rxCnt_q == '0) begin
          rxShift_d = {rxSync_q, rxShift_q[7:1]};
          rxCnt_d   = BIT_RELOAD;
          if (rxBit_q == 3'd7) begin
            rxState_d = STOP;
          end else begin
            rxBit_d = rxBit_q + 3'd1;
          end
        end else begin
          rxCnt_d = rxCnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (rxCnt_q == '0) begin
          rxState_d = IDLE;
          if (rxSync_q) begin
            rxPush       = 1'b1;
            rxOverrunSet = rxFull && !rxPop;
          end else begin
            frameErrSet = 1'b1;
          end
        end else begin
          rxCnt_d = rxCnt_q - CNT_ONE;
        end
      end
      default: rxState_d = IDLE;
    endcase
  end
endmodule
